// File: rtl/case_eqv_pkg.sv
// Shared types and defaults for the sequential equivalence sweeper.
// The optional macro CASE_EQV_STOP_ON_FAIL_EN ends a sweep at its first mismatch.
package case_eqv_pkg;

    localparam int CASE_N_IN  = 10;
    localparam int CASE_N_OUT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/case_eqv_cmp.sv
// Compares golden and revised responses for one vector per cycle.
// Counts mismatches and keeps the first failing vector and its diff.
module case_eqv_cmp
    import case_eqv_pkg::*;
#(
    parameter int N_IN  = CASE_N_IN,
    parameter int N_OUT = CASE_N_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [N_IN-1:0]  vec_i,
    input  logic [N_OUT-1:0] gold_i,
    input  logic [N_OUT-1:0] rev_i,
    output logic             mismatch_o,
    output logic [N_IN:0]    fail_cnt_o,
    output logic [N_IN-1:0]  first_fail_vec_o,
    output logic             first_fail_vld_o,
    output logic [N_OUT-1:0] fail_diff_o
);

    logic [N_OUT-1:0] diff;

    // Single-cycle combinational compare of the current vector
    always_comb begin
        diff       = gold_i ^ rev_i;
        mismatch_o = |diff;
    end

    // Mismatch counter and first-fail capture, cleared on sweep start
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            fail_cnt_o       <= '0;
            first_fail_vec_o <= '0;
            first_fail_vld_o <= 1'b0;
            fail_diff_o      <= '0;
        end else if (en_i && mismatch_o) begin
            fail_cnt_o <= fail_cnt_o + 1'b1;
            if (!first_fail_vld_o) begin
                first_fail_vec_o <= vec_i;
                first_fail_vld_o <= 1'b1;
                fail_diff_o      <= diff;
            end
        end
    end

endmodule

// File: rtl/case_eqv_seq.sv
// Exhaustive stimulus sweeper comparing two netlists vector by vector.
// Define CASE_EQV_STOP_ON_FAIL_EN to finish the sweep at the first mismatch.
module case_eqv_seq
    import case_eqv_pkg::*;
#(
    parameter int N_IN  = CASE_N_IN,
    parameter int N_OUT = CASE_N_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic [N_IN-1:0]  vec_o,
    input  logic [N_OUT-1:0] gold_i,
    input  logic [N_OUT-1:0] rev_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [N_IN:0]    fail_cnt_o,
    output logic [N_IN-1:0]  first_fail_vec_o,
    output logic             first_fail_vld_o,
    output logic [N_OUT-1:0] fail_diff_o
);

    state_t state, state_nxt;
    logic   mismatch;
    logic   last_vec;
    logic   stop_hit;
    logic   start_ok;
    logic   sweep_en;

    assign last_vec = &vec_o;

`ifdef CASE_EQV_STOP_ON_FAIL_EN
    assign stop_hit = mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_i) state_nxt = SWEEP;
            SWEEP:   if (last_vec || stop_hit) state_nxt = DONE;
            DONE:    if (start_i) state_nxt = SWEEP;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs and datapath controls
    always_comb begin
        busy_o   = (state == SWEEP);
        done_o   = (state == DONE);
        pass_o   = done_o && (fail_cnt_o == '0);
        sweep_en = busy_o;
        start_ok = start_i && (state == IDLE || state == DONE);
    end

    // Stimulus counter: cleared on start, stepped each sweep cycle
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            vec_o <= '0;
        else if (sweep_en && !last_vec && !stop_hit)
            vec_o <= vec_o + 1'b1;
    end

    case_eqv_cmp #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_cmp (
        .clk              (clk),
        .rst              (rst),
        .clr_i            (start_ok),
        .en_i             (sweep_en),
        .vec_i            (vec_o),
        .gold_i           (gold_i),
        .rev_i            (rev_i),
        .mismatch_o       (mismatch),
        .fail_cnt_o       (fail_cnt_o),
        .first_fail_vec_o (first_fail_vec_o),
        .first_fail_vld_o (first_fail_vld_o),
        .fail_diff_o      (fail_diff_o)
    );

endmodule

// File: doc/case_eqv_seq.md
CASE_EQV_SEQ -- requirements
Module: case_eqv_seq

Interface
REQ-001 Parameter N_IN, default 10: width of the stimulus vector driven to both netlists under comparison.
REQ-002 Parameter N_OUT, default 5: width of each netlist response bus.
REQ-003 clk input 1: single clock; all state updates occur on its rising edge.
REQ-004 rst input 1: reset, synchronous, active-high.
REQ-005 start_i input 1: sweep request, sampled only in IDLE or DONE.
REQ-006 vec_o output N_IN: registered stimulus, drives inputs a..j of both the golden and the revised netlist instances.
REQ-007 gold_i input N_OUT: golden netlist outputs y1..y5, combinational from vec_o.
REQ-008 rev_i input N_OUT: revised netlist outputs y1..y5, combinational from vec_o.
REQ-009 busy_o output 1: high while state is SWEEP.
REQ-010 done_o output 1: high while state is DONE.
REQ-011 pass_o output 1: in DONE, high iff fail_cnt_o is 0; low outside DONE.
REQ-012 fail_cnt_o output N_IN+1: number of mismatching vectors in the current or last sweep.
REQ-013 first_fail_vec_o output N_IN: vec_o value at the first mismatch; valid only when first_fail_vld_o is high.
REQ-014 first_fail_vld_o output 1: set at the first mismatch of a sweep.
REQ-015 fail_diff_o output N_OUT: gold_i XOR rev_i captured at the first mismatch.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, SWEEP and DONE, and SHALL encode them as a shared enum.
- IDLE/DONE, start_i=1 at edge E0: go to SWEEP; vec_o=0; clear fail_cnt_o, first_fail_vld_o, first_fail_vec_o and fail_diff_o.
- SWEEP: start_i ignored.
- DONE: state held until start_i or rst.
REQ-017 In SWEEP, each edge SHALL compare gold_i with rev_i for the current vec_o (single-cycle combinational path, no pipeline stage).
- On mismatch: fail_cnt_o increments.
- On the first mismatch of a sweep: capture first_fail_vec_o and fail_diff_o, and set first_fail_vld_o.
REQ-018 At the end of each SWEEP edge:
- If vec_o equals all-ones, the next state SHALL be DONE and vec_o SHALL hold.
- Otherwise vec_o SHALL increment by 1.
REQ-019 Latency SHALL be fixed: vector k is compared at edge E(k+1), busy_o is high for exactly 2^N_IN cycles, and done_o rises after edge E(2^N_IN).
REQ-020 fail_cnt_o SHALL NOT wrap, because its maximum value of 2^N_IN fits in N_IN+1 bits.
REQ-021 A mismatch on the all-ones vector SHALL be counted before the transition to DONE.

Reset
REQ-022 When rst=1 at an edge, including mid-SWEEP, the block SHALL return to IDLE with all outputs at reset values:
- vec_o=0, busy_o=0, done_o=0, pass_o=0.
- fail_cnt_o=0, first_fail_vec_o=0, first_fail_vld_o=0, fail_diff_o=0.
REQ-023 rst SHALL take priority over start_i.

Configuration
REQ-024 With macro CASE_EQV_STOP_ON_FAIL_EN defined, the first mismatch SHALL move the FSM to DONE at that same edge.
- vec_o holds the failing vector.
- fail_cnt_o=1.
REQ-025 Without CASE_EQV_STOP_ON_FAIL_EN, the sweep SHALL always cover all 2^N_IN vectors.

Structure
REQ-026 A shared package case_eqv_pkg SHALL hold:
- the state enum (IDLE, SWEEP, DONE);
- default constants CASE_N_IN=10 and CASE_N_OUT=5.
REQ-027 The comparison and first-fail capture SHALL live in one sub-module, case_eqv_cmp; the FSM and vector counter SHALL remain in case_eqv_seq.
REQ-028 The netlists under comparison SHALL be instantiated outside this block, by the bench or wrapper.

Verification
REQ-029 Tie rev_i=gold_i and pulse start_i at E0 -> busy_o high for 1024 cycles, done_o=1 after E1024, pass_o=1, fail_cnt_o=0, first_fail_vld_o=0.
REQ-030 Force rev_i=gold_i^5'b00100 only when vec_o=10'h2A5 -> fail_cnt_o=1, first_fail_vec_o=10'h2A5, fail_diff_o=5'b00100, pass_o=0.
REQ-031 Force rev_i=gold_i^5'b10000 for vec_o>=10'h3FE:
- Without the macro -> fail_cnt_o=2, first_fail_vec_o=10'h3FE, done_o after E1024.
- With the macro -> done_o=1 after E1023, vec_o=10'h3FE, fail_cnt_o=1.
REQ-032 Assert rst for one edge while vec_o=10'h100 -> all outputs at reset values the next cycle, state IDLE.
REQ-033 Pulse start_i while vec_o=10'h010 in SWEEP -> no effect, sweep completes normally. Pulse start_i in DONE after a failing sweep -> counters and first-fail fields cleared, vec_o=0, busy_o=1 the next cycle.
